cntrl_spi_regs: RTL
===================

// Module: cntrl_spi_regs
// PURPOSE
//  Control register bank directly downstream of spi_slave. Decodes the 7-bit register address, holds
//  all control/status registers, and drives rd_data back to spi_slave for MISO serialization.
//  Generates sub-block reset pulses, a W1C interrupt, ADC DPRAM address stepping and DDC/audio controls.
// PARAMETERS
//  ID_VALUE     32'h1C7A0001  constant returned by REG_ID
//  N_RST        4             number of software reset outputs (RST_CNTRL bits [N_RST-1:0])
//  RST_PULSE    16            reset pulse length in clk cycles (>=1)
//  N_IRQ        8             number of interrupt sources
//  DPRAM_AW     10            ADC DPRAM address width
// PORTS
//  clk             in   1         system clock
//  reset           in   1         synchronous, active-high
//  addr            in   7         register address from spi_slave
//  wr_data         in   32        write data (spi_slave data_out)
//  wr_en           in   1         1-cycle write strobe, addr/wr_data valid
//  rd_en           in   1         1-cycle read-commit strobe (side effects only)
//  rd_data         out  32        read data to spi_slave data_in, combinational from addr
//  rst_out         out  N_RST     sub-block reset pulses, active-high
//  irq_src         in   N_IRQ     level interrupt sources, rising edge sets status
//  irq             out  1         |(status & enable), registered
//  led             out  4         LED_CNTRL[3:0]
//  dpram_addr      out  DPRAM_AW  ADC DPRAM read address
//  dpram_rd_data   in   32        ADC DPRAM data at dpram_addr (1-cycle RAM latency)
//  dpram_cap_en    out  1         ADC_DPRAM_CNTRL[0]
//  ddc_cntrl       out  32        DDC_CNTRL
//  ddc_lo_freq     out  32        DDC_LO_FREQ
//  ddc_lo_upd      out  1         1-cycle pulse the cycle after a DDC_LO_FREQ write
//  i2s_mux_sel     out  4         AUDIO_I2S_MUX_SEL[3:0]
// BEHAVIOUR
//  Map: 00 ID(RO) 01 RST_CNTRL 02 IRQ_CNTRL_STATUS 03 LED_CNTRL 10 ADC_DPRAM_CNTRL 11 ADC_DPRAM_ADDR
//   12 ADC_DPRAM_DATA(RO) 20 DDC_CNTRL 21 DDC_LO_FREQ 30 AUDIO_I2S_MUX_SEL; unmapped: read 0, write ignored.
//  Reset: all registers, outputs, counters 0; rst_out=0, irq=0, ddc_lo_upd=0. Unused reg bits read 0.
//  rd_data: pure mux of addr, no latency; stable while addr stable. RO writes ignored.
//  RST_CNTRL: write loads per-bit counter to RST_PULSE for each 1 bit; rst_out[i]=(cnt[i]!=0) from next
//   cycle for exactly RST_PULSE cycles; rewrite mid-pulse reloads (extends). Reads return rst_out.
//  IRQ_CNTRL_STATUS: [N_IRQ-1:0] status W1C, [N_IRQ+15:16] enable RW. Edge det: irq_src registered once.
//   Same-cycle set and W1C clear on a bit: set wins. irq = registered |(status&enable).
//  ADC_DPRAM_CNTRL: [0] cap_en, [1] auto_inc. ADC_DPRAM_ADDR RW = dpram_addr.
//  ADC_DPRAM_DATA: returns dpram_rd_data; rd_en at this addr with auto_inc=1 -> dpram_addr+1 next cycle,
//   wrapping 2^DPRAM_AW-1 -> 0. Write to ADDR in same cycle as increment: write wins.
//  rd_en and wr_en same cycle: write applied and read side effect applied (write wins on conflict).
//  Reset asserted mid-pulse/mid-transaction: everything returns to reset values next edge.
// STRUCTURE
//  Package cntrl_spi_pkg: 7-bit address localparams (CNTRL_SPI_REG_*), ID_VALUE default, bit positions.
//  Sub-module rst_pulse_gen (one per rst_out bit): load/counter/active-high pulse of RST_PULSE cycles.
// TESTING
//  Reset, addr=00 -> rd_data=32'h1C7A0001; addr=03 -> 0; all outputs 0.
//  wr 03 <= 32'hFFFF_FFF5 -> led=4'h5, read 03 = 32'h5; wr 7F <= any -> no register changes, read 7F = 0.
//  wr 01 <= 32'h5 -> rst_out=4'b0101 for exactly 16 cycles; rewrite bit0 at cycle 10 -> bit0 high 26 total.
//  wr 02 <= 32'h0001_0000; rise irq_src[0] -> status[0]=1, irq=1; wr 02 <= 32'h0001_0001 -> irq=0;
//   same-cycle irq_src edge and W1C -> status stays 1.
//  wr 10 <= 2, wr 11 <= 3FE; dpram model data=addr; two rd_en at 12 -> reads 3FE, 3FF, dpram_addr wraps to 0.
//  wr 21 <= 32'h1234_5678 -> ddc_lo_freq=32'h12345678, ddc_lo_upd one cycle; wr 20 <= 32'hDDC0AA0C reads back.

Source files
------------

// File: rtl/cntrl_spi_pkg.sv
// Shared constants for the SPI control register bank: register map,
// identification value and field positions inside the multi-field registers.
package cntrl_spi_pkg;

  // Register map (7-bit addresses as delivered by spi_slave)
  localparam logic [6:0] CNTRL_SPI_REG_ID                = 7'h00;
  localparam logic [6:0] CNTRL_SPI_REG_RST_CNTRL         = 7'h01;
  localparam logic [6:0] CNTRL_SPI_REG_IRQ_CNTRL_STATUS  = 7'h02;
  localparam logic [6:0] CNTRL_SPI_REG_LED_CNTRL         = 7'h03;
  localparam logic [6:0] CNTRL_SPI_REG_ADC_DPRAM_CNTRL   = 7'h10;
  localparam logic [6:0] CNTRL_SPI_REG_ADC_DPRAM_ADDR    = 7'h11;
  localparam logic [6:0] CNTRL_SPI_REG_ADC_DPRAM_DATA    = 7'h12;
  localparam logic [6:0] CNTRL_SPI_REG_DDC_CNTRL         = 7'h20;
  localparam logic [6:0] CNTRL_SPI_REG_DDC_LO_FREQ       = 7'h21;
  localparam logic [6:0] CNTRL_SPI_REG_AUDIO_I2S_MUX_SEL = 7'h30;

  // Default identification word returned by the ID register
  localparam logic [31:0] CNTRL_SPI_ID_VALUE = 32'h1C7A_0001;

  // IRQ_CNTRL_STATUS: status occupies the low bits, enables start here
  localparam int IRQ_EN_LSB = 16;

  // ADC_DPRAM_CNTRL field layout, bit 0 = capture enable, bit 1 = auto increment
  typedef struct packed {
    logic auto_inc;
    logic cap_en;
  } dpram_cntrl_t;

endpackage

// File: rtl/rst_pulse_gen.sv
// One software reset channel: a load strobe arms a down-counter and the
// output stays high while the counter is non-zero, i.e. for exactly
// RST_PULSE cycles after the load. Reloading mid-pulse restarts the count.
module rst_pulse_gen #(
  parameter int RST_PULSE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic pulse
);

  localparam int CW = $clog2(RST_PULSE + 1);

  logic [CW-1:0] cnt;

  // Pulse length counter: load has priority over the decrement
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(RST_PULSE);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign pulse = (cnt != '0);

endmodule

// File: rtl/cntrl_spi_regs.sv
// Control/status register bank behind spi_slave. Decodes the register
// address, holds every control register, returns combinational read data
// for MISO serialisation and generates reset pulses, a W1C interrupt,
// ADC DPRAM address stepping and DDC/audio controls.
module cntrl_spi_regs
  import cntrl_spi_pkg::*;
#(
  parameter logic [31:0] ID_VALUE  = CNTRL_SPI_ID_VALUE,
  parameter int          N_RST     = 4,
  parameter int          RST_PULSE = 16,
  parameter int          N_IRQ     = 8,
  parameter int          DPRAM_AW  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          addr,
  input  logic [31:0]         wr_data,
  input  logic                wr_en,
  input  logic                rd_en,
  output logic [31:0]         rd_data,
  output logic [N_RST-1:0]    rst_out,
  input  logic [N_IRQ-1:0]    irq_src,
  output logic                irq,
  output logic [3:0]          led,
  output logic [DPRAM_AW-1:0] dpram_addr,
  input  logic [31:0]         dpram_rd_data,
  output logic                dpram_cap_en,
  output logic [31:0]         ddc_cntrl,
  output logic [31:0]         ddc_lo_freq,
  output logic                ddc_lo_upd,
  output logic [3:0]          i2s_mux_sel
);

  // Per-register write strobes
  logic wr_rst, wr_irq, wr_led, wr_dp_cntrl, wr_dp_addr;
  logic wr_ddc_cntrl, wr_ddc_lo, wr_i2s;
  logic dp_step;

  assign wr_rst       = wr_en && (addr == CNTRL_SPI_REG_RST_CNTRL);
  assign wr_irq       = wr_en && (addr == CNTRL_SPI_REG_IRQ_CNTRL_STATUS);
  assign wr_led       = wr_en && (addr == CNTRL_SPI_REG_LED_CNTRL);
  assign wr_dp_cntrl  = wr_en && (addr == CNTRL_SPI_REG_ADC_DPRAM_CNTRL);
  assign wr_dp_addr   = wr_en && (addr == CNTRL_SPI_REG_ADC_DPRAM_ADDR);
  assign wr_ddc_cntrl = wr_en && (addr == CNTRL_SPI_REG_DDC_CNTRL);
  assign wr_ddc_lo    = wr_en && (addr == CNTRL_SPI_REG_DDC_LO_FREQ);
  assign wr_i2s       = wr_en && (addr == CNTRL_SPI_REG_AUDIO_I2S_MUX_SEL);

  // Register storage
  dpram_cntrl_t     dp_cntrl;
  logic [N_IRQ-1:0] irq_status, irq_en, irq_src_q, irq_rise, irq_clr;

  // A committed read of the data window steps the address when auto_inc is set
  assign dp_step = rd_en && (addr == CNTRL_SPI_REG_ADC_DPRAM_DATA) && dp_cntrl.auto_inc;

  // Software reset channels, one pulse generator per bit
  for (genvar i = 0; i < N_RST; i++) begin : g_rst
    rst_pulse_gen #(.RST_PULSE(RST_PULSE)) u_rst_pulse_gen (
      .clk   (clk),
      .reset (reset),
      .load  (wr_rst && wr_data[i]),
      .pulse (rst_out[i])
    );
  end

  // Interrupt edge detection and W1C clear mask
  assign irq_rise = irq_src & ~irq_src_q;
  assign irq_clr  = wr_irq ? wr_data[N_IRQ-1:0] : '0;

  // Interrupt status/enable and registered interrupt output; a new edge beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_src_q  <= '0;
      irq_status <= '0;
      irq_en     <= '0;
      irq        <= 1'b0;
    end else begin
      irq_src_q  <= irq_src;
      irq_status <= (irq_status & ~irq_clr) | irq_rise;
      if (wr_irq) irq_en <= wr_data[IRQ_EN_LSB +: N_IRQ];
      irq        <= |(irq_status & irq_en);
    end
  end

  // Plain control registers, DPRAM address stepping and LO update strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      led         <= '0;
      dp_cntrl    <= '0;
      dpram_addr  <= '0;
      ddc_cntrl   <= '0;
      ddc_lo_freq <= '0;
      ddc_lo_upd  <= 1'b0;
      i2s_mux_sel <= '0;
    end else begin
      if (wr_led)       led         <= wr_data[3:0];
      if (wr_dp_cntrl)  dp_cntrl    <= wr_data[1:0];
      if (wr_ddc_cntrl) ddc_cntrl   <= wr_data;
      if (wr_ddc_lo)    ddc_lo_freq <= wr_data;
      if (wr_i2s)       i2s_mux_sel <= wr_data[3:0];
      ddc_lo_upd <= wr_ddc_lo;
      // Explicit write wins over the auto increment; the increment wraps naturally
      if (wr_dp_addr) begin
        dpram_addr <= wr_data[DPRAM_AW-1:0];
      end else if (dp_step) begin
        dpram_addr <= dpram_addr + DPRAM_AW'(1);
      end
    end
  end

  assign dpram_cap_en = dp_cntrl.cap_en;

  // Read data mux, purely combinational from addr
  always_comb begin
    // NOTE: the default assignment up front keeps this block from inferring
    // latches for any address or bit not explicitly covered below.
    rd_data = '0;
    unique case (addr)
      CNTRL_SPI_REG_ID:                rd_data = ID_VALUE;
      CNTRL_SPI_REG_RST_CNTRL:         rd_data[N_RST-1:0] = rst_out;
      CNTRL_SPI_REG_IRQ_CNTRL_STATUS: begin
        rd_data[N_IRQ-1:0]            = irq_status;
        rd_data[IRQ_EN_LSB +: N_IRQ]  = irq_en;
      end
      CNTRL_SPI_REG_LED_CNTRL:         rd_data[3:0] = led;
      CNTRL_SPI_REG_ADC_DPRAM_CNTRL:   rd_data[1:0] = dp_cntrl;
      CNTRL_SPI_REG_ADC_DPRAM_ADDR:    rd_data[DPRAM_AW-1:0] = dpram_addr;
      CNTRL_SPI_REG_ADC_DPRAM_DATA:    rd_data = dpram_rd_data;
      CNTRL_SPI_REG_DDC_CNTRL:         rd_data = ddc_cntrl;
      CNTRL_SPI_REG_DDC_LO_FREQ:       rd_data = ddc_lo_freq;
      CNTRL_SPI_REG_AUDIO_I2S_MUX_SEL: rd_data[3:0] = i2s_mux_sel;
      default:                         rd_data = '0;
    endcase
  end

endmodule
